// File: rtl/monitor_cuenta_if.sv
// Bus between the loadable down-counter side and monitor_cuenta.
// With MONITOR_CUENTA_IRQ_EN defined the bus also carries irq / irq_ack.
interface monitor_cuenta_if #(
    parameter int N         = 2,
    parameter int W_EVENTOS = 8
);
    logic                 habilitar;
    logic [N-1:0]         cuenta;
    logic                 fin;
    logic                 en_cero;
    logic                 estancado;
    logic [W_EVENTOS-1:0] eventos;
    logic [1:0]           estado;
`ifdef MONITOR_CUENTA_IRQ_EN
    // irq is a level request: it stays high until the consumer pulses irq_ack.
    logic                 irq;
    logic                 irq_ack;

    modport master (output habilitar, cuenta, irq_ack,
                    input  fin, en_cero, estancado, eventos, estado, irq);
    modport slave  (input  habilitar, cuenta, irq_ack,
                    output fin, en_cero, estancado, eventos, estado, irq);
`else
    modport master (output habilitar, cuenta,
                    input  fin, en_cero, estancado, eventos, estado);
    modport slave  (input  habilitar, cuenta,
                    output fin, en_cero, estancado, eventos, estado);
`endif
endinterface

// File: rtl/monitor_cuenta.sv
// Countdown supervisor: end-of-count pulse, zero flag, expiry counter, sticky stall flag.
// Optional latched interrupt enabled by defining MONITOR_CUENTA_IRQ_EN.
module monitor_cuenta #(
    parameter int N             = 2,
    parameter int W_EVENTOS     = 8,
    parameter int MAX_ESTANCADO = 4
) (
    input  logic             clock,
    input  logic             reset,
    monitor_cuenta_if.slave  bus
);
    localparam int SW = $clog2(MAX_ESTANCADO + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_ESTANCADO);

    typedef enum logic [1:0] {
        INACTIVO  = 2'b00,
        ESPERA    = 2'b01,
        CONTANDO  = 2'b10,
        TERMINADO = 2'b11
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [N-1:0]         previo_q;
    logic [SW-1:0]        stall_q, stall_d, stall_inc;
    logic                 fin_q, fin_d;
    logic                 en_cero_q;
    logic                 estancado_q, estancado_d;
    logic [W_EVENTOS-1:0] eventos_q, eventos_d;

    assign stall_inc = stall_q + SW'(1);

    always_comb begin
        estado_d    = estado_q;
        stall_d     = stall_q;
        fin_d       = 1'b0;
        estancado_d = estancado_q;
        eventos_d   = eventos_q;
        if (!bus.habilitar) begin
            estado_d = INACTIVO;
        end else begin
            case (estado_q)
                INACTIVO: estado_d = ESPERA;
                ESPERA: begin
                    if (bus.cuenta != '0) begin
                        estado_d = CONTANDO;
                        stall_d  = '0;
                    end
                end
                CONTANDO: begin
                    if (bus.cuenta == '0) begin
                        estado_d = TERMINADO;
                        fin_d    = 1'b1;
                        stall_d  = '0;
                        if (eventos_q != '1) eventos_d = eventos_q + W_EVENTOS'(1);
                    end else if (bus.cuenta > previo_q) begin
                        stall_d = '0;
                    end else if (bus.cuenta == previo_q) begin
                        // Saturate at the threshold so a long stall cannot wrap the counter.
                        if (stall_q != STALL_MAX) begin
                            stall_d = stall_inc;
                            if (stall_inc == STALL_MAX) estancado_d = 1'b1;
                        end
                    end else begin
                        stall_d = '0;
                    end
                end
                TERMINADO: begin
                    if (bus.cuenta != '0) begin
                        estado_d = CONTANDO;
                        stall_d  = '0;
                    end
                end
                default: estado_d = INACTIVO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= INACTIVO;
            previo_q    <= '0;
            stall_q     <= '0;
            fin_q       <= 1'b0;
            en_cero_q   <= 1'b0;
            estancado_q <= 1'b0;
            eventos_q   <= '0;
        end else begin
            estado_q    <= estado_d;
            previo_q    <= bus.cuenta;
            stall_q     <= stall_d;
            fin_q       <= fin_d;
            en_cero_q   <= (bus.cuenta == '0);
            estancado_q <= estancado_d;
            eventos_q   <= eventos_d;
        end
    end

`ifdef MONITOR_CUENTA_IRQ_EN
    logic irq_q;

    // A new fin beats a simultaneous acknowledge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)            irq_q <= 1'b0;
        else if (fin_d)        irq_q <= 1'b1;
        else if (bus.irq_ack)  irq_q <= 1'b0;
    end

    assign bus.irq = irq_q;
`endif

    assign bus.fin       = fin_q;
    assign bus.en_cero   = en_cero_q;
    assign bus.estancado = estancado_q;
    assign bus.eventos   = eventos_q;
    assign bus.estado    = estado_q;
endmodule
